comm_demux_router: RTL and testbench

- Parametrised, registered channel router for the simple comm system.
- Accepts one data word with a channel select over a valid/ready handshake.
- Decodes the select to one-hot and presents the word to the chosen channel, or to all channels in broadcast mode.
- Holds the word until every targeted channel has accepted it.
- Successor to the fixed 2-to-4 decoder: generic width, non-power-of-2 channel count, backpressure, broadcast and out-of-range error reporting.

---
 rtl/comm_pkg.sv | 21 ++
 rtl/comm_demux_router_if.sv | 29 ++
 rtl/comm_demux_router_onehot_dec_n.sv | 16 +
 rtl/comm_demux_router.sv | 89 ++++++++
 tb/tb_comm_demux_router.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// Shared types and helpers for the comm channel router.
package comm_pkg;

    localparam int unsigned MAX_CH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // n-bit one-hot of sel in the low bits; all zero when sel is out of range.
    function automatic logic [MAX_CH-1:0] onehot_of(input int unsigned sel, input int unsigned n);
        logic [MAX_CH-1:0] mask;
        mask = '0;
        if (sel < n && sel < MAX_CH) begin
            mask[sel] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/comm_demux_router_if.sv
// Upstream word handshake plus per-channel fan-out bus of the router.
interface comm_demux_router_if #(
    parameter int SEL_W  = 2,
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic              in_bcast;
    logic [DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] sel_onehot;
    logic              err_pulse;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output in_valid, in_sel, in_bcast, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel_onehot, err_pulse, drop_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_bcast, in_data, out_ready,
        output in_ready, out_valid, out_data, sel_onehot, err_pulse, drop_cnt
    );
endinterface

// File: rtl/comm_demux_router_onehot_dec_n.sv
// Combinational select decoder for a channel count that need not be a power of two.
module onehot_dec_n #(
    parameter int SEL_W  = 2,
    parameter int NUM_CH = 4
) (
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] onehot,
    output logic              in_range
);
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
        assign onehot[gi] = (sel == SEL_W'(gi));
    end

    // Selects at or above NUM_CH light no bit, which is exactly the drop case.
    assign in_range = |onehot;
endmodule

// File: rtl/comm_demux_router.sv
// Registered channel router: holds one word until every targeted channel has taken it.
module comm_demux_router
    import comm_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    comm_demux_router_if.slave bus
);
    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0] sel_oh_q, sel_oh_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic [NUM_CH-1:0] dec_onehot;
    logic              dec_in_range;
    logic              done;
    logic              accept;

    onehot_dec_n #(
        .SEL_W (SEL_W),
        .NUM_CH(NUM_CH)
    ) u_dec (
        .sel     (bus.in_sel),
        .onehot  (dec_onehot),
        .in_range(dec_in_range)
    );

    // Combinational out_ready -> in_ready path: lets a new word land in the
    // same cycle the last pending channel accepts (zero-bubble streaming).
    assign done   = (state_q == IDLE) || ((pend_q & ~bus.out_ready) == '0);
    assign accept = bus.in_valid & done;

    always_comb begin
        pend_d   = pend_q & ~bus.out_ready;
        data_d   = data_q;
        sel_oh_d = sel_oh_q;
        err_d    = 1'b0;
        drop_d   = drop_q;
        if (accept) begin
            if (bus.in_bcast) begin
                pend_d   = '1;
                sel_oh_d = '1;
                data_d   = bus.in_data;
            end else if (dec_in_range) begin
                pend_d   = dec_onehot;
                sel_oh_d = dec_onehot;
                data_d   = bus.in_data;
            end else begin
                pend_d   = '0;
                sel_oh_d = '0;
                err_d    = 1'b1;
                drop_d   = (drop_q == {CNT_W{1'b1}}) ? drop_q : drop_q + 1'b1;
            end
        end
        state_d = (pend_d != '0) ? HOLD : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            data_q   <= '0;
            sel_oh_q <= '0;
            err_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            sel_oh_q <= sel_oh_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.in_ready   = done;
    assign bus.out_valid  = pend_q;
    assign bus.out_data   = data_q;
    assign bus.sel_onehot = sel_oh_q;
    assign bus.err_pulse  = err_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_comm_demux_router.sv
// Vector table plus pending-mask scoreboard for a 3-channel router with 2-bit select.
module tb_comm_demux_router;
    localparam int SEL_W  = 2;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int NVEC   = 26;

    logic clk;
    logic rst;

    comm_demux_router_if #(
        .SEL_W(SEL_W), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) bus ();

    comm_demux_router #(
        .SEL_W(SEL_W), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic       bc;
        logic [7:0] d;
        logic [2:0] rdy;
        logic       e_irdy;
        logic [2:0] e_ov;
        logic [7:0] e_od;
        logic [2:0] e_oh;
        logic       e_err;
        logic [7:0] e_drop;
    } vec_t;

    typedef struct packed {
        logic [2:0] mask;
        logic [7:0] data;
    } sb_t;

    vec_t vecs[NVEC];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mirror of the pending mask: front entry is the word currently presented.
    task automatic sb_step(input logic v, input logic [1:0] sel, input logic bc,
                           input logic [7:0] d, input logic [2:0] rdy);
        logic       model_done;
        logic [2:0] m;
        sb_t        e;
        model_done = (sb_q.size() == 0) || ((sb_q[0].mask & ~rdy) == 3'b000);
        chk("sb_in_ready", 32'(bus.in_ready), 32'(model_done));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_out_valid", 32'(bus.out_valid), 32'(e.mask));
            if ((e.mask & rdy) != 3'b000)
                chk("sb_out_data", 32'(bus.out_data), 32'(e.data));
            e.mask = e.mask & ~rdy;
            if (e.mask != 3'b000) sb_q.push_front(e);
        end else begin
            chk("sb_out_valid_idle", 32'(bus.out_valid), 32'd0);
        end
        if (v && model_done) begin
            m = bc ? 3'b111 : (sel < 2'd3) ? (3'b001 << sel) : 3'b000;
            if (m != 3'b000) sb_q.push_back('{mask: m, data: d});
        end
    endtask

    task automatic do_cycle(input logic v, input logic [1:0] sel, input logic bc,
                            input logic [7:0] d, input logic [2:0] rdy, output logic irdy_pre);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_bcast  = bc;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        irdy_pre = bus.in_ready;
        sb_step(v, sel, bc, d, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       irdy;
        logic [7:0] exp_drop;

        //            v  sel   bc  d      rdy     irdy ov      od     oh      err  drop
        vecs[0]  = '{1, 2'd2, 0, 8'hA5, 3'b111, 1, 3'b100, 8'hA5, 3'b100, 0, 8'd0};
        vecs[1]  = '{0, 2'd0, 0, 8'h00, 3'b111, 1, 3'b000, 8'hA5, 3'b100, 0, 8'd0};
        vecs[2]  = '{1, 2'd1, 0, 8'h3C, 3'b000, 1, 3'b010, 8'h3C, 3'b010, 0, 8'd0};
        vecs[3]  = '{1, 2'd0, 0, 8'hFF, 3'b101, 0, 3'b010, 8'h3C, 3'b010, 0, 8'd0};
        vecs[4]  = '{1, 2'd0, 0, 8'hFF, 3'b101, 0, 3'b010, 8'h3C, 3'b010, 0, 8'd0};
        vecs[5]  = '{1, 2'd0, 0, 8'hFF, 3'b101, 0, 3'b010, 8'h3C, 3'b010, 0, 8'd0};
        vecs[6]  = '{1, 2'd0, 0, 8'hFF, 3'b101, 0, 3'b010, 8'h3C, 3'b010, 0, 8'd0};
        vecs[7]  = '{1, 2'd0, 0, 8'hFF, 3'b101, 0, 3'b010, 8'h3C, 3'b010, 0, 8'd0};
        vecs[8]  = '{0, 2'd0, 0, 8'h00, 3'b010, 1, 3'b000, 8'h3C, 3'b010, 0, 8'd0};
        vecs[9]  = '{1, 2'd3, 1, 8'h77, 3'b000, 1, 3'b111, 8'h77, 3'b111, 0, 8'd0};
        vecs[10] = '{0, 2'd0, 0, 8'h00, 3'b101, 0, 3'b010, 8'h77, 3'b111, 0, 8'd0};
        vecs[11] = '{0, 2'd0, 0, 8'h00, 3'b010, 1, 3'b000, 8'h77, 3'b111, 0, 8'd0};
        vecs[12] = '{1, 2'd3, 0, 8'h99, 3'b000, 1, 3'b000, 8'h77, 3'b000, 1, 8'd1};
        vecs[13] = '{1, 2'd3, 0, 8'h98, 3'b000, 1, 3'b000, 8'h77, 3'b000, 1, 8'd2};
        vecs[14] = '{0, 2'd0, 0, 8'h00, 3'b000, 1, 3'b000, 8'h77, 3'b000, 0, 8'd2};
        vecs[15] = '{1, 2'd0, 0, 8'h01, 3'b111, 1, 3'b001, 8'h01, 3'b001, 0, 8'd2};
        vecs[16] = '{1, 2'd1, 0, 8'h02, 3'b111, 1, 3'b010, 8'h02, 3'b010, 0, 8'd2};
        vecs[17] = '{1, 2'd2, 0, 8'h03, 3'b111, 1, 3'b100, 8'h03, 3'b100, 0, 8'd2};
        vecs[18] = '{1, 2'd0, 0, 8'h04, 3'b111, 1, 3'b001, 8'h04, 3'b001, 0, 8'd2};
        vecs[19] = '{1, 2'd1, 0, 8'h05, 3'b111, 1, 3'b010, 8'h05, 3'b010, 0, 8'd2};
        vecs[20] = '{0, 2'd0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h05, 3'b010, 0, 8'd2};
        vecs[21] = '{1, 2'd0, 1, 8'h5A, 3'b000, 1, 3'b111, 8'h5A, 3'b111, 0, 8'd2};
        vecs[22] = '{1, 2'd2, 0, 8'h11, 3'b111, 1, 3'b100, 8'h11, 3'b100, 0, 8'd2};
        vecs[23] = '{0, 2'd0, 0, 8'h00, 3'b000, 0, 3'b100, 8'h11, 3'b100, 0, 8'd2};
        vecs[24] = '{0, 2'd0, 0, 8'h00, 3'b011, 0, 3'b100, 8'h11, 3'b100, 0, 8'd2};
        vecs[25] = '{0, 2'd0, 0, 8'h00, 3'b100, 1, 3'b000, 8'h11, 3'b100, 0, 8'd2};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_bcast  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'd0);
        chk("reset_sel_onehot", 32'(bus.sel_onehot), 32'd0);
        chk("reset_err_pulse", 32'(bus.err_pulse), 32'd0);
        chk("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            do_cycle(vecs[i].v, vecs[i].sel, vecs[i].bc, vecs[i].d, vecs[i].rdy, irdy);
            chk($sformatf("vec%0d_in_ready", i), 32'(irdy), 32'(vecs[i].e_irdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].e_od));
            chk($sformatf("vec%0d_sel_onehot", i), 32'(bus.sel_onehot), 32'(vecs[i].e_oh));
            chk($sformatf("vec%0d_err_pulse", i), 32'(bus.err_pulse), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_drop_cnt", i), 32'(bus.drop_cnt), 32'(vecs[i].e_drop));
            $display("vec %0d: ov=%b od=%h oh=%b err=%b drop=%0d", i, bus.out_valid,
                     bus.out_data, bus.sel_onehot, bus.err_pulse, bus.drop_cnt);
        end

        // Drop counter saturation: 300 more out-of-range accepts on top of the two above.
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'b1, 2'd3, 1'b0, 8'hE0, 3'b000, irdy);
            exp_drop = (i + 3 > 255) ? 8'd255 : 8'(i + 3);
            chk("sat_in_ready", 32'(irdy), 32'd1);
            chk("sat_err_pulse", 32'(bus.err_pulse), 32'd1);
            chk("sat_out_valid", 32'(bus.out_valid), 32'd0);
            chk("sat_drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
        end
        $display("saturation: drop=%0d", bus.drop_cnt);
        do_cycle(1'b0, 2'd0, 1'b0, 8'h00, 3'b000, irdy);
        chk("sat_idle_err_pulse", 32'(bus.err_pulse), 32'd0);
        chk("sat_idle_drop_cnt", 32'(bus.drop_cnt), 32'd255);

        // Async reset while a word is held on channel 2.
        do_cycle(1'b1, 2'd2, 1'b0, 8'hC3, 3'b000, irdy);
        chk("rsthold_out_valid", 32'(bus.out_valid), 32'b100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rsthold_out_valid_async", 32'(bus.out_valid), 32'd0);
        chk("rsthold_out_data_async", 32'(bus.out_data), 32'd0);
        chk("rsthold_sel_onehot_async", 32'(bus.sel_onehot), 32'd0);
        chk("rsthold_drop_cnt_async", 32'(bus.drop_cnt), 32'd0);
        chk("rsthold_in_ready_async", 32'(bus.in_ready), 32'd1);
        $display("async reset: ov=%b od=%h drop=%0d", bus.out_valid, bus.out_data, bus.drop_cnt);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 2'd0, 1'b0, 8'h00, 3'b000, irdy);
            chk("postrst_in_ready", 32'(irdy), 32'd1);
            chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        end

        chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
